// File: rtl/term_loopback_pipe.sv
// term_loopback_pipe: segment-reversing loopback with selectable bypass,
// registered, tie-off and LFSR-pattern output modes, configured through a
// 2-bit serial shift chain.
module term_loopback_pipe #(
    parameter int unsigned W1         = 4,
    parameter int unsigned W2         = 8,
    parameter int unsigned W4         = 16,
    parameter int unsigned DEPTH      = 1,
    parameter logic [1:0]  RESET_MODE = 2'b00,
    localparam int unsigned W         = W1 + 2 * W2 + W4
) (
    input  logic         UserCLK,
    input  logic         RST_N,
    input  logic         cfg_en,
    input  logic         cfg_in,
    input  logic         cfg_load,
    output logic         cfg_out,
    input  logic [W-1:0] n_in,
    output logic [W-1:0] s_out,
    output logic [1:0]   mode_o
);

    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'b00,
        MODE_PIPED   = 2'b01,
        MODE_TIEOFF  = 2'b10,
        MODE_PATTERN = 2'b11
    } mode_e;

    localparam int unsigned O_2MID    = W1;
    localparam int unsigned O_2END    = W1 + W2;
    localparam int unsigned O_4END    = W1 + 2 * W2;
    localparam int unsigned LFSR_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Reject pipeline depths outside 1..4 at elaboration.
    if (DEPTH == 0 || DEPTH > 4) begin : g_bad_depth
        $error("term_loopback_pipe: DEPTH must be in 1..4");
    end

    logic [1:0]   sh_q, sh_d;
    mode_e        mode_q, mode_d;
    logic [15:0]  lfsr_q, lfsr_d;
    logic         reseed_c;
    logic [W-1:0] rev_c;
    logic [W-1:0] pat_c;
    logic [W-1:0] pipe_q [DEPTH];

    // Bit-reverse each segment independently.
    always_comb begin
        rev_c = '0;
        for (int unsigned i = 0; i < W1; i++) begin
            rev_c[i] = n_in[W1 - 1 - i];
        end
        for (int unsigned i = 0; i < W2; i++) begin
            rev_c[O_2MID + i] = n_in[O_2MID + W2 - 1 - i];
            rev_c[O_2END + i] = n_in[O_2END + W2 - 1 - i];
        end
        for (int unsigned i = 0; i < W4; i++) begin
            rev_c[O_4END + i] = n_in[O_4END + W4 - 1 - i];
        end
    end

    // Tile the 16-bit LFSR state across the full output width.
    always_comb begin
        pat_c = '0;
        for (int unsigned i = 0; i < W; i++) begin
            pat_c[i] = lfsr_q[i % LFSR_W];
        end
    end

    // Next-state for config chain, active mode and pattern generator.
    always_comb begin
        sh_d     = sh_q;
        mode_d   = mode_q;
        lfsr_d   = lfsr_q;
        reseed_c = 1'b0;
        if (cfg_en) begin
            sh_d = {sh_q[0], cfg_in};
        end
        if (cfg_load) begin
            // Loads the pre-shift value, so a same-cycle shift does not leak in.
            mode_d = mode_e'(sh_q);
        end
        reseed_c = cfg_load && (sh_q == 2'b11) && (mode_q != MODE_PATTERN);
        if (reseed_c) begin
            lfsr_d = LFSR_SEED;
        end else if (mode_q == MODE_PATTERN) begin
            // Taps x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form.
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    // Config chain, mode and LFSR state registers.
    always_ff @(posedge UserCLK or negedge RST_N) begin
        if (!RST_N) begin
            sh_q   <= 2'b00;
            mode_q <= mode_e'(RESET_MODE);
            lfsr_q <= LFSR_SEED;
        end else begin
            sh_q   <= sh_d;
            mode_q <= mode_d;
            lfsr_q <= lfsr_d;
        end
    end

    // Delay line runs in every mode so switching to piped shows real history.
    always_ff @(posedge UserCLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q[0] <= rev_c;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                pipe_q[k] <= pipe_q[k - 1];
            end
        end
    end

    // Output select; bypass is intentionally combinational.
    always_comb begin
        s_out = '0;
        case (mode_q)
            MODE_BYPASS:  s_out = rev_c;
            MODE_PIPED:   s_out = pipe_q[DEPTH - 1];
            MODE_TIEOFF:  s_out = '0;
            MODE_PATTERN: s_out = pat_c;
            default:      s_out = '0;
        endcase
    end

    assign cfg_out = sh_q[1];
    assign mode_o  = mode_q;

    // The pattern generator must never lock up in the all-zero state.
    a_lfsr_nonzero: assert property (@(posedge UserCLK) disable iff (!RST_N) lfsr_q != 16'h0000);

endmodule
